// File: rtl/ct_l2cache_data_seq_pkg.sv
// Shared definitions for the L2 data-array line sequencer.
//   L2C_DATA_INDEX_WIDTH : SRAM row index width (1M configuration)
//   L2C_DATA_BEATS       : 128-bit beats per 64B line
//   seq_state_t          : sequencer FSM states
package ct_l2cache_data_seq_pkg;

    localparam int unsigned L2C_DATA_INDEX_WIDTH = 13;
    localparam int unsigned L2C_DATA_BEATS       = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } seq_state_t;

endpackage

// File: rtl/ct_l2cache_data_rdpipe.sv
// Read-return pipeline for the L2 data sequencer.
// Delays a valid/beat tag by RD_LAT cycles so that it lines up with SRAM Q,
// then writes Q into the matching 128-bit slot of the assembled line.
//   forever_cpuclk : clock
//   cpurst_b       : asynchronous reset, active-low (discards in-flight tags)
//   issue_vld      : a read beat is on the SRAM pins this cycle
//   issue_beat     : beat number of that read
//   data_dout      : SRAM Q
//   rdata          : assembled 512-bit line
module ct_l2cache_data_rdpipe #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic         forever_cpuclk,
    input  logic         cpurst_b,
    input  logic         issue_vld,
    input  logic [1:0]   issue_beat,
    input  logic [127:0] data_dout,
    output logic [511:0] rdata
);

    logic [RD_LAT-1:0] vld_pipe;
    logic [1:0]        beat_pipe [RD_LAT];
    logic              cap_vld;
    logic [1:0]        cap_beat;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            vld_pipe <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                beat_pipe[i] <= '0;
            end
        end else begin
            vld_pipe[0]  <= issue_vld;
            beat_pipe[0] <= issue_beat;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                beat_pipe[i] <= beat_pipe[i-1];
            end
        end
    end

    assign cap_vld  = vld_pipe[RD_LAT-1];
    assign cap_beat = beat_pipe[RD_LAT-1];

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rdata <= '0;
        end else if (cap_vld) begin
            rdata[128*cap_beat +: 128] <= data_dout;
        end
    end

endmodule

// File: rtl/ct_l2cache_data_seq.sv
// L2 data SRAM line sequencer.
// Accepts one 64B line request, issues it as 4 x 128-bit beats on registered
// active-low SRAM pins, and returns either a wr_done pulse or the read line.
//   forever_cpuclk / cpurst_b       : clock, asynchronous active-low reset
//   req_vld/req_rdy/req_wr/req_idx  : line request handshake and address
//   req_wdata/req_bwen              : write line and active-high byte enables
//   wr_done / rdata_vld / rdata     : completion pulses and read line
//   data_cen/gwen/wen/idx/din/dout  : SRAM wrapper interface
module ct_l2cache_data_seq
    import ct_l2cache_data_seq_pkg::*;
#(
    parameter int unsigned DATA_INDEX_WIDTH = L2C_DATA_INDEX_WIDTH,
    parameter int unsigned RD_LAT           = 1
) (
    input  logic                        forever_cpuclk,
    input  logic                        cpurst_b,
    input  logic                        req_vld,
    output logic                        req_rdy,
    input  logic                        req_wr,
    input  logic [DATA_INDEX_WIDTH-3:0] req_idx,
    input  logic [511:0]                req_wdata,
    input  logic [63:0]                 req_bwen,
    output logic                        wr_done,
    output logic                        rdata_vld,
    output logic [511:0]                rdata,
    output logic                        data_cen,
    output logic                        data_gwen,
    output logic [127:0]                data_wen,
    output logic [DATA_INDEX_WIDTH-1:0] data_idx,
    output logic [127:0]                data_din,
    input  logic [127:0]                data_dout
);

    localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

    seq_state_t                  state_q, state_d;
    logic [1:0]                  cnt_q, cnt_d;
    logic                        wr_q;
    logic [DATA_INDEX_WIDTH-3:0] idx_q;
    logic [511:0]                wdata_q;
    logic [63:0]                 bwen_q;
    logic                        accept;

    // Request fields feeding the pin registers: on the accept edge the latch
    // is not loaded yet, so beat 0 is taken straight from the request port.
    logic                        src_wr;
    logic [DATA_INDEX_WIDTH-3:0] src_idx;
    logic [511:0]                src_wdata;
    logic [63:0]                 src_bwen;
    logic [15:0]                 bwen_beat;

    logic                        cen_d, gwen_d;
    logic [127:0]                wen_d, din_d;
    logic [DATA_INDEX_WIDTH-1:0] idx_d;

    assign accept = req_vld && (state_q == ST_IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_ACCESS;
                    cnt_d   = '0;
                end
            end
            ST_ACCESS: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = wr_q ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                // counter wrapped to 0 leaving ACCESS; reused as latency count
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == WAIT_LAST) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        src_wr    = accept ? req_wr    : wr_q;
        src_idx   = accept ? req_idx   : idx_q;
        src_wdata = accept ? req_wdata : wdata_q;
        src_bwen  = accept ? req_bwen  : bwen_q;
        bwen_beat = src_bwen[16*cnt_d +: 16];

        cen_d  = 1'b1;
        gwen_d = 1'b1;
        wen_d  = '1;
        idx_d  = data_idx;
        din_d  = data_din;
        if (state_d == ST_ACCESS) begin
            idx_d = {src_idx, cnt_d};
            if (src_wr) begin
                cen_d  = ~|bwen_beat;
                gwen_d = 1'b0;
                for (int unsigned j = 0; j < 16; j++) begin
                    wen_d[8*j +: 8] = {8{~bwen_beat[j]}};
                end
                din_d = src_wdata[128*cnt_d +: 128];
            end else begin
                cen_d = 1'b0;
            end
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            wr_q      <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            bwen_q    <= '0;
            data_cen  <= 1'b1;
            data_gwen <= 1'b1;
            data_wen  <= '1;
            data_idx  <= '0;
            data_din  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_cen  <= cen_d;
            data_gwen <= gwen_d;
            data_wen  <= wen_d;
            data_idx  <= idx_d;
            data_din  <= din_d;
            if (accept) begin
                wr_q    <= req_wr;
                idx_q   <= req_idx;
                wdata_q <= req_wdata;
                bwen_q  <= req_bwen;
            end
        end
    end

    assign req_rdy   = (state_q == ST_IDLE);
    assign wr_done   = (state_q == ST_DONE) &&  wr_q;
    assign rdata_vld = (state_q == ST_DONE) && !wr_q;

    // A read beat is on the pins whenever CEN is low with GWEN high.
    ct_l2cache_data_rdpipe #(
        .RD_LAT (RD_LAT)
    ) u_rdpipe (
        .forever_cpuclk (forever_cpuclk),
        .cpurst_b       (cpurst_b),
        .issue_vld      (~data_cen & data_gwen),
        .issue_beat     (data_idx[1:0]),
        .data_dout      (data_dout),
        .rdata          (rdata)
    );

endmodule

// File: tb/tb_ct_l2cache_data_seq.sv
module tb_ct_l2cache_data_seq;
    import ct_l2cache_data_seq_pkg::*;

    localparam int unsigned IW   = 13;
    localparam int unsigned LAT1 = 1;
    localparam int unsigned LAT3 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // DUT with RD_LAT=1
    logic          req_vld, req_rdy, req_wr;
    logic [IW-3:0] req_idx;
    logic [511:0]  req_wdata;
    logic [63:0]   req_bwen;
    logic          wr_done, rdata_vld;
    logic [511:0]  rdata;
    logic          cen, gwen;
    logic [127:0]  wen, din, dout;
    logic [IW-1:0] sidx;

    // DUT with RD_LAT=3
    logic          req3_vld, req3_rdy, req3_wr;
    logic [IW-3:0] req3_idx;
    logic [511:0]  req3_wdata;
    logic [63:0]   req3_bwen;
    logic          wr3_done, rdata3_vld;
    logic [511:0]  rdata3;
    logic          cen3, gwen3;
    logic [127:0]  wen3, din3, dout3;
    logic [IW-1:0] sidx3;

    ct_l2cache_data_seq #(.DATA_INDEX_WIDTH(IW), .RD_LAT(LAT1)) u_dut (
        .forever_cpuclk(clk), .cpurst_b(rst_n),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr), .req_idx(req_idx),
        .req_wdata(req_wdata), .req_bwen(req_bwen),
        .wr_done(wr_done), .rdata_vld(rdata_vld), .rdata(rdata),
        .data_cen(cen), .data_gwen(gwen), .data_wen(wen), .data_idx(sidx),
        .data_din(din), .data_dout(dout)
    );

    ct_l2cache_data_seq #(.DATA_INDEX_WIDTH(IW), .RD_LAT(LAT3)) u_dut3 (
        .forever_cpuclk(clk), .cpurst_b(rst_n),
        .req_vld(req3_vld), .req_rdy(req3_rdy), .req_wr(req3_wr), .req_idx(req3_idx),
        .req_wdata(req3_wdata), .req_bwen(req3_bwen),
        .wr_done(wr3_done), .rdata_vld(rdata3_vld), .rdata(rdata3),
        .data_cen(cen3), .data_gwen(gwen3), .data_wen(wen3), .data_idx(sidx3),
        .data_din(din3), .data_dout(dout3)
    );

    // Behavioural SRAM models: bit-masked write, Q valid RD_LAT cycles after the sample edge.
    logic [127:0] mem1 [2**IW] = '{default: '0};
    logic [127:0] q1   [LAT1]  = '{default: '0};
    always @(posedge clk) begin
        if (!cen) begin
            if (!gwen) mem1[sidx] <= (mem1[sidx] & wen) | (din & ~wen);
            else       q1[0] <= mem1[sidx];
        end
        for (int i = 1; i < LAT1; i++) q1[i] <= q1[i-1];
    end
    assign dout = q1[LAT1-1];

    logic [127:0] mem3 [2**IW] = '{default: '0};
    logic [127:0] q3   [LAT3]  = '{default: '0};
    always @(posedge clk) begin
        if (!cen3) begin
            if (!gwen3) mem3[sidx3] <= (mem3[sidx3] & wen3) | (din3 & ~wen3);
            else        q3[0] <= mem3[sidx3];
        end
        for (int i = 1; i < LAT3; i++) q3[i] <= q3[i-1];
    end
    assign dout3 = q3[LAT3-1];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          wr;
        logic [IW-3:0] idx;
        logic [511:0]  wdata;
        logic [63:0]   bwen;
        logic          hold;
        logic [511:0]  exp_rdata;
    } vec_t;

    vec_t vecs [12];

    // Issue one request at the current (post-negedge) time and check every
    // cycle from T+1 until req_rdy returns.
    task automatic run_req(input vec_t v);
        int unsigned  waits;
        int unsigned  last;
        logic [15:0]  bb;
        logic [127:0] exp_wen;
        req_wr    = v.wr;
        req_idx   = v.idx;
        req_wdata = v.wdata;
        req_bwen  = v.bwen;
        req_vld   = 1'b1;
        waits = 0;
        while (!req_rdy && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        chk("accept_wait", waits, 0);
        last = v.wr ? 6 : 6 + LAT1;
        for (int unsigned c = 1; c <= last; c++) begin
            @(negedge clk);
            if (c == 1 && !v.hold) req_vld = 1'b0;
            chk("req_rdy", req_rdy, c == last);
            chk("wr_done", wr_done, v.wr && c == 5);
            chk("rdata_vld", rdata_vld, !v.wr && c == 5 + LAT1);
            if (c <= 4) begin
                bb = v.bwen[16*(c-1) +: 16];
                chk("cen", cen, v.wr ? (bb == 16'h0) : 1'b0);
                chk("gwen", gwen, !v.wr);
                chk("data_idx", sidx, {v.idx, 2'(c-1)});
                if (v.wr) begin
                    for (int j = 0; j < 16; j++) exp_wen[8*j +: 8] = {8{~bb[j]}};
                    chk("wen", wen, exp_wen);
                    if (bb != 16'h0) chk("din", din, v.wdata[128*(c-1) +: 128]);
                end else begin
                    chk("wen_rd", wen, {128{1'b1}});
                end
            end else begin
                chk("cen_outside", cen, 1'b1);
                chk("wen_outside", wen, {128{1'b1}});
            end
            if (!v.wr && c == 5 + LAT1) chk("rdata", rdata, v.exp_rdata);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [511:0] w1, w2, w3, w4, w5, w6, e2, e4, e6, p;
        int unsigned  waits;

        rst_n = 1'b0;
        req_vld = 1'b0; req_wr = 1'b0; req_idx = '0; req_wdata = '0; req_bwen = '0;
        req3_vld = 1'b0; req3_wr = 1'b0; req3_idx = '0; req3_wdata = '0; req3_bwen = '0;
        repeat (2) @(negedge clk);

        chk("rst_req_rdy", req_rdy, 1'b1);
        chk("rst_wr_done", wr_done, 1'b0);
        chk("rst_rdata_vld", rdata_vld, 1'b0);
        chk("rst_rdata", rdata, 512'h0);
        chk("rst_cen", cen, 1'b1);
        chk("rst_gwen", gwen, 1'b1);
        chk("rst_wen", wen, {128{1'b1}});
        chk("rst_idx", sidx, 13'h0);
        chk("rst_din", din, 128'h0);
        chk("rst_req3_rdy", req3_rdy, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);

        w1 = {{4{32'hA000_0003}}, {4{32'hA000_0002}}, {4{32'hA000_0001}}, {4{32'hA000_0000}}};
        w2 = {16{32'h5A5A_C3C3}};
        e2 = {w1[511:32], 32'h5A5A_C3C3};
        w3 = {16{32'hFFFF_FFFF}};
        w4 = {16{32'h1234_5678}};
        e4 = {{4{32'h1234_5678}}, 256'h0, {4{32'h1234_5678}}};
        w5 = {16{32'hDEAD_BEEF}};
        w6 = 512'h0;
        e6 = {32'h0, {15{32'hDEAD_BEEF}}};

        //           wr    idx      wdata bwen                    hold  exp_rdata
        vecs[0]  = '{1'b1, 11'h005, w1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 512'h0};
        vecs[1]  = '{1'b0, 11'h005, w3, 64'h0,                   1'b0, w1};
        vecs[2]  = '{1'b1, 11'h005, w2, 64'h0000_0000_0000_000F, 1'b0, 512'h0};
        vecs[3]  = '{1'b0, 11'h005, w3, 64'h0,                   1'b0, e2};
        vecs[4]  = '{1'b1, 11'h005, w3, 64'h0,                   1'b0, 512'h0};
        vecs[5]  = '{1'b0, 11'h005, w3, 64'h0,                   1'b0, e2};
        vecs[6]  = '{1'b1, 11'h1FF, w4, 64'hFFFF_0000_0000_FFFF, 1'b0, 512'h0};
        vecs[7]  = '{1'b0, 11'h1FF, w3, 64'h0,                   1'b0, e4};
        vecs[8]  = '{1'b1, 11'h02A, w5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 512'h0};
        vecs[9]  = '{1'b0, 11'h02A, w3, 64'h0,                   1'b1, w5};
        vecs[10] = '{1'b1, 11'h02A, w6, 64'hF000_0000_0000_0000, 1'b1, 512'h0};
        vecs[11] = '{1'b0, 11'h02A, w3, 64'h0,                   1'b1, e6};

        for (int i = 0; i < 12; i++) run_req(vecs[i]);
        req_vld = 1'b0;

        // RD_LAT=3: fill line 0x1FF, then read it back with timing checks.
        p = {{4{32'hC000_0003}}, {4{32'hC000_0002}}, {4{32'hC000_0001}}, {4{32'hC000_0000}}};
        req3_wr = 1'b1; req3_idx = 11'h1FF; req3_wdata = p; req3_bwen = '1; req3_vld = 1'b1;
        chk("t4_wr_accept", req3_rdy, 1'b1);
        @(negedge clk);
        req3_vld = 1'b0;
        waits = 0;
        while (!req3_rdy && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        chk("t4_wr_spacing", waits, 5);
        req3_wr = 1'b0; req3_vld = 1'b1;
        chk("t4_rd_accept", req3_rdy, 1'b1);
        for (int unsigned c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 1) req3_vld = 1'b0;
            chk("t4_rdata_vld", rdata3_vld, c == 8);
            chk("t4_req_rdy", req3_rdy, c == 9);
            chk("t4_cen", cen3, c > 4);
            if (c == 8) chk("t4_rdata", rdata3, p);
        end

        // Reset during beat 2 of a read.
        req_wr = 1'b0; req_idx = 11'h005; req_bwen = '0; req_vld = 1'b1;
        chk("t5_accept", req_rdy, 1'b1);
        @(negedge clk);
        req_vld = 1'b0;
        repeat (2) @(negedge clk);
        chk("t5_cen_beat2", cen, 1'b0);
        chk("t5_idx_beat2", sidx, {11'h005, 2'd2});
        #1 rst_n = 1'b0;
        #1;
        chk("t5_cen_async", cen, 1'b1);
        chk("t5_rdata_clr", rdata, 512'h0);
        chk("t5_rdy_async", req_rdy, 1'b1);
        chk("t5_rdata_vld", rdata_vld, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("t5_no_vld", rdata_vld, 1'b0);
            chk("t5_no_done", wr_done, 1'b0);
            chk("t5_cen_idle", cen, 1'b1);
            chk("t5_rdy", req_rdy, 1'b1);
            chk("t5_rdata_hold", rdata, 512'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
